// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture fill path.
package adc_capture_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StArmed   = 4'b0010,
        StCapture = 4'b0100,
        StDone    = 4'b1000
    } state_e;

    localparam int unsigned NumCh  = 4;
    localparam int unsigned PhaseW = 3;
    localparam int unsigned Ratio1 = 1;
    localparam int unsigned Ratio2 = 2;
    localparam int unsigned Ratio4 = 4;
    localparam int unsigned Ratio8 = 8;

    // Sample k goes to a ratio-n FIFO when the low log2(n) phase bits are zero.
    function automatic logic [PhaseW-1:0] ratio_mask(input int unsigned ratio);
        return PhaseW'(ratio - 1);
    endfunction

endpackage

// File: rtl/adc_capture_writer_channel.sv
// One decimated FIFO channel: write strobe, write counter, done and short-fill detection.
module capture_channel
    import adc_capture_pkg::*;
#(
    parameter int unsigned       DEPTH = 8192,
    parameter logic [PhaseW-1:0] MASK  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              active,
    input  logic              accept,
    input  logic [PhaseW-1:0] phase,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic              done,
    output logic              short_flag
);

    localparam int unsigned     CntW   = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [CntW-1:0] count_q, count_d;
    logic            done_q, done_d;
    logic            short_q, short_d;
    logic            wr_en_q, wr_en_d;
    logic            hit, short_seen;

    always_comb begin
        hit        = accept && ((phase & MASK) == '0) && !done_q && !fifo_full;
        short_seen = active && fifo_full && !done_q && (count_q < DepthC);
        count_d    = count_q;
        done_d     = done_q;
        short_d    = short_q;
        wr_en_d    = hit;
        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
            short_d = 1'b0;
            wr_en_d = 1'b0;
        end else begin
            if (hit) begin
                count_d = count_q + CntW'(1);
                if (count_d == DepthC) begin
                    done_d = 1'b1;
                end
            end
            // FIFO filled early: retire the channel and flag the short capture.
            if (short_seen) begin
                done_d  = 1'b1;
                short_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
            short_q <= short_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign done       = done_q;
    assign short_flag = short_q;

endmodule

// File: rtl/adc_capture_writer.sv
// Fill side of the four-FIFO ADC capture path (decimation 1/2/4/8).
// Define ADC_CAPTURE_TRIGGER_EN to start capture on a rising crossing of trig_level.
module adc_capture_writer
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              full1,
    input  logic              full2,
    input  logic              full4,
    input  logic              full8,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty4,
    input  logic              empty8,
    output logic [DATA_W-1:0] din,
    output logic              wr_en1,
    output logic              wr_en2,
    output logic              wr_en4,
    output logic              wr_en8,
    output logic              full,
    output logic              busy,
    output logic              short_err
);

    state_e            state_q, state_d;
    logic [PhaseW-1:0] phase_q;
    logic [DATA_W-1:0] din_q;
    logic              clear, accept, trig_ok, all_empty;
    logic [NumCh-1:0]  fifo_full, ch_wr, ch_done, ch_short;

    assign fifo_full = {full8, full4, full2, full1};
    assign all_empty = empty1 & empty2 & empty4 & empty8;

`ifdef ADC_CAPTURE_TRIGGER_EN
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clear) begin
            prev_valid_q <= 1'b0;
        end else if (state_q == StArmed && adc_valid) begin
            prev_q       <= adc_data;
            prev_valid_q <= 1'b1;
        end
    end

    assign trig_ok = prev_valid_q && (prev_q < trig_level) && (adc_data >= trig_level);
`else
    logic unused_trig;
    assign unused_trig = ^trig_level;
    assign trig_ok     = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StArmed;
                    clear   = 1'b1;
                end
            end
            StArmed: begin
                if (adc_valid && trig_ok) begin
                    accept  = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                accept = adc_valid;
                if (&ch_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (all_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                phase_q <= '0;
            end else if (accept) begin
                phase_q <= phase_q + PhaseW'(1);
            end
            if (accept) begin
                din_q <= adc_data;
            end
        end
    end

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        capture_channel #(
            .DEPTH (DEPTH),
            .MASK  (ratio_mask(1 << i))
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear),
            .active     (busy),
            .accept     (accept),
            .phase      (phase_q),
            .fifo_full  (fifo_full[i]),
            .wr_en      (ch_wr[i]),
            .done       (ch_done[i]),
            .short_flag (ch_short[i])
        );
    end

    assign din       = din_q;
    assign wr_en1    = ch_wr[0];
    assign wr_en2    = ch_wr[1];
    assign wr_en4    = ch_wr[2];
    assign wr_en8    = ch_wr[3];
    assign full      = (state_q == StDone);
    assign busy      = (state_q == StArmed) || (state_q == StCapture);
    assign short_err = |ch_short;

endmodule

// File: tb/tb_adc_capture_writer.sv
// Randomized self-checking bench for adc_capture_writer with a queue-based reference model.
module tb_adc_capture_writer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              full1, full2, full4, full8;
    logic              empty1, empty2, empty4, empty8;
    logic [DATA_W-1:0] din;
    logic              wr_en1, wr_en2, wr_en4, wr_en8;
    logic              full, busy, short_err;

    adc_capture_writer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .trig_level (trig_level),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .full1      (full1),
        .full2      (full2),
        .full4      (full4),
        .full8      (full8),
        .empty1     (empty1),
        .empty2     (empty2),
        .empty4     (empty4),
        .empty8     (empty8),
        .din        (din),
        .wr_en1     (wr_en1),
        .wr_en2     (wr_en2),
        .wr_en4     (wr_en4),
        .wr_en8     (wr_en8),
        .full       (full),
        .busy       (busy),
        .short_err  (short_err)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   got_q[4][$];
    int   exp_q[4][$];
    int   acc_q[$];
    int   base[4];
    int   bad_gap  = 0;
    logic prev_valid = 1'b0;
    int   full_iter, last_iter;

    // Collects every FIFO write; also counts writes that follow a cycle with adc_valid low.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en1) got_q[0].push_back(int'(din));
            if (wr_en2) got_q[1].push_back(int'(din));
            if (wr_en4) got_q[2].push_back(int'(din));
            if (wr_en8) got_q[3].push_back(int'(din));
            if ((wr_en1 | wr_en2 | wr_en4 | wr_en8) && !prev_valid) bad_gap <= bad_gap + 1;
            prev_valid <= adc_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic set_empty(input logic [3:0] e);
        {empty8, empty4, empty2, empty1} = e;
    endtask

    // Drains a finished capture, arms, streams samples until full, and builds expected FIFOs.
    // vmode: 0 continuous, 1 toggle, 2 random (with stray arm pulses); dmode: 0 ramp, 1 random,
    // 2 trigger ramp 90,95,99,100,101...; short4 > 0 forces full4 after that many FIFO4 writes.
    task automatic run_capture(input int vmode, input int dmode, input int short4);
        int nvalid = 0;
        int prev   = -1;
        int cur;
        bit trig;
        bit v;
        for (int i = 0; i < 4; i++) begin
            base[i] = got_q[i].size();
            exp_q[i].delete();
        end
        acc_q.delete();
        full_iter = -1;
        last_iter = -1;
        if (full) begin
            set_empty(4'hf);
            @(posedge clk); #1;
            set_empty(4'h0);
        end
        arm = 1'b1; adc_valid = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
`ifdef ADC_CAPTURE_TRIGGER_EN
        trig = 1'b0;
`else
        trig = 1'b1;
`endif
        for (int it = 0; it < 3000 && full_iter < 0; it++) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((it % 2) == 0) : ($urandom_range(0, 3) != 0);
            case (dmode)
                0:       cur = nvalid & 16'hffff;
                1:       cur = int'($urandom_range(0, 65535));
                default: cur = (nvalid == 0) ? 90 : (nvalid == 1) ? 95 : (nvalid == 2) ? 99
                               : 97 + nvalid;
            endcase
            adc_valid = v;
            adc_data  = cur[15:0];
            arm       = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            full4     = (short4 > 0) && (got_q[2].size() - base[2] >= short4);
            if (v) begin
                nvalid++;
                if (!trig) begin
                    if (prev >= 0 && prev < int'(trig_level) && cur >= int'(trig_level)) trig = 1'b1;
                    prev = cur;
                end
                if (trig) begin
                    acc_q.push_back(cur);
                    if (acc_q.size() == 8 * DEPTH - 7) last_iter = it;
                end
            end
            @(negedge clk);
            if (full) full_iter = it;
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
        arm       = 1'b0;
        full4     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int n   = 1 << i;
            int lim = (i == 2 && short4 > 0) ? short4 : DEPTH;
            for (int k = 0; k < acc_q.size() && exp_q[i].size() < lim; k += n)
                exp_q[i].push_back(acc_q[k]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; arm = 1'b0; adc_valid = 1'b0; adc_data = '0; trig_level = '0;
        {full8, full4, full2, full1} = 4'h0;
        set_empty(4'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (din !== '0) begin failures++; $display("FAIL reset_din got=%0h required=0", din); end
        checks++; if ({wr_en8, wr_en4, wr_en2, wr_en1} !== 4'h0) begin
            failures++; $display("FAIL reset_wr_en got=%b required=0000", {wr_en8, wr_en4, wr_en2, wr_en1});
        end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b required=0", full); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (short_err !== 1'b0) begin
            failures++; $display("FAIL reset_short_err got=%b required=0", short_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp;
        int gap0 = bad_gap;
        trig_level = 16'd20;
        run_capture(0, 0, 0);
        checks++; if (full_iter < 0) begin failures++; $display("FAIL ramp_timeout got=no_full required=full"); end
        checks++; if (full_iter != last_iter + 2) begin
            failures++; $display("FAIL ramp_full_latency got=%0d required=%0d", full_iter - last_iter, 2);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i].size() - base[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL ramp_fifo%0d_count got=%0d required=%0d", 1 << i, got_q[i].size() - base[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && base[i] + k < got_q[i].size(); k++) begin
                checks++;
                if (got_q[i][base[i] + k] != exp_q[i][k]) begin
                    failures++;
                    $display("FAIL ramp_fifo%0d_data[%0d] got=%0d required=%0d", 1 << i, k, got_q[i][base[i] + k], exp_q[i][k]);
                end
            end
        end
`ifndef ADC_CAPTURE_TRIGGER_EN
        checks++; if (got_q[3].size() != base[3] + DEPTH || got_q[3][base[3] + DEPTH - 1] != 8 * DEPTH - 8) begin
            failures++; $display("FAIL ramp_fifo8_last got_count=%0d required=%0d", got_q[3].size() - base[3], 8 * DEPTH - 8);
        end
`endif
        checks++; if (short_err !== 1'b0) begin failures++; $display("FAIL ramp_short_err got=%b required=0", short_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_done got=%b required=0", busy); end
        checks++; if (bad_gap != gap0) begin failures++; $display("FAIL ramp_gap got=%0d required=0", bad_gap - gap0); end
    endtask

    task automatic test_done_handshake;
        logic [3:0] e = 4'h0;
        for (int i = 0; i < 3; i++) begin
            e[i] = 1'b1;
            set_empty(e);
            @(negedge clk);
            checks++; if (full !== 1'b1) begin failures++; $display("FAIL done_hold%0d got=%b required=1", i, full); end
            @(posedge clk); #1;
        end
        set_empty(4'hf);
        @(negedge clk);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL done_last_cycle got=%b required=1", full); end
        @(posedge clk); #1;
        set_empty(4'h0);
        checks++; if (full !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL done_to_idle got=full%b_busy%b required=full0_busy0", full, busy);
        end
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL done_rearm got=%b required=1", busy); end
    endtask

    task automatic test_toggle;
        int gap0 = bad_gap;
        trig_level = 16'd20;
        run_capture(1, 0, 0);
        checks++; if (full_iter < 0) begin failures++; $display("FAIL toggle_timeout got=no_full required=full"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i].size() - base[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL toggle_fifo%0d_count got=%0d required=%0d", 1 << i, got_q[i].size() - base[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && base[i] + k < got_q[i].size(); k++) begin
                checks++;
                if (got_q[i][base[i] + k] != exp_q[i][k]) begin
                    failures++;
                    $display("FAIL toggle_fifo%0d_data[%0d] got=%0d required=%0d", 1 << i, k, got_q[i][base[i] + k], exp_q[i][k]);
                end
            end
        end
        checks++; if (bad_gap != gap0) begin
            failures++; $display("FAIL toggle_write_after_idle got=%0d required=0", bad_gap - gap0);
        end
    endtask

    task automatic test_short4;
        trig_level = 16'd32768;
        run_capture(0, 1, 5);
        checks++; if (full_iter < 0) begin failures++; $display("FAIL short_timeout got=no_full required=full"); end
        checks++; if (got_q[2].size() - base[2] != 5) begin
            failures++; $display("FAIL short_fifo4_count got=%0d required=5", got_q[2].size() - base[2]);
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < exp_q[i].size() && base[i] + k < got_q[i].size(); k++) begin
                checks++;
                if (got_q[i][base[i] + k] != exp_q[i][k]) begin
                    failures++;
                    $display("FAIL short_fifo%0d_data[%0d] got=%0d required=%0d", 1 << i, k, got_q[i][base[i] + k], exp_q[i][k]);
                end
            end
        end
        checks++; if (short_err !== 1'b1) begin failures++; $display("FAIL short_err_flag got=%b required=1", short_err); end
    endtask

    task automatic test_random;
        trig_level = 16'd32768;
        run_capture(2, 1, 0);
        checks++; if (full_iter < 0) begin failures++; $display("FAIL random_timeout got=no_full required=full"); end
        checks++; if (full_iter != last_iter + 2) begin
            failures++; $display("FAIL random_full_latency got=%0d required=%0d", full_iter - last_iter, 2);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i].size() - base[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL random_fifo%0d_count got=%0d required=%0d", 1 << i, got_q[i].size() - base[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && base[i] + k < got_q[i].size(); k++) begin
                checks++;
                if (got_q[i][base[i] + k] != exp_q[i][k]) begin
                    failures++;
                    $display("FAIL random_fifo%0d_data[%0d] got=%0d required=%0d", 1 << i, k, got_q[i][base[i] + k], exp_q[i][k]);
                end
            end
        end
        checks++; if (short_err !== 1'b0) begin
            failures++; $display("FAIL random_short_cleared got=%b required=0", short_err);
        end
    endtask

    task automatic test_reset_mid;
        trig_level = 16'd32768;
        set_empty(4'hf);
        @(posedge clk); #1;
        set_empty(4'h0);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adc_valid = 1'b1;
            adc_data  = (i % 2 == 1) ? 16'hffff : 16'h0000;
            @(posedge clk); #1;
        end
        checks++; if (wr_en1 !== 1'b1) begin failures++; $display("FAIL midrst_pre_wr_en1 got=%b required=1", wr_en1); end
        rst = 1'b1;
        #1;
        checks++; if ({wr_en8, wr_en4, wr_en2, wr_en1} !== 4'h0) begin
            failures++; $display("FAIL midrst_wr_en got=%b required=0000", {wr_en8, wr_en4, wr_en2, wr_en1});
        end
        checks++; if (full !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midrst_full_busy got=full%b_busy%b required=full0_busy0", full, busy);
        end
        adc_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_capture(0, 1, 0);
        checks++; if (full_iter < 0) begin failures++; $display("FAIL midrst_timeout got=no_full required=full"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i].size() - base[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL midrst_fifo%0d_count got=%0d required=%0d", 1 << i, got_q[i].size() - base[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && base[i] + k < got_q[i].size(); k++) begin
                checks++;
                if (got_q[i][base[i] + k] != exp_q[i][k]) begin
                    failures++;
                    $display("FAIL midrst_fifo%0d_data[%0d] got=%0d required=%0d", 1 << i, k, got_q[i][base[i] + k], exp_q[i][k]);
                end
            end
        end
    endtask

`ifdef ADC_CAPTURE_TRIGGER_EN
    task automatic test_trigger;
        trig_level = 16'd100;
        run_capture(0, 2, 0);
        checks++; if (full_iter < 0) begin failures++; $display("FAIL trig_timeout got=no_full required=full"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i].size() <= base[i] || got_q[i][base[i]] != 100) begin
                failures++;
                $display("FAIL trig_fifo%0d_first got=%0d required=100", 1 << i,
                         (got_q[i].size() > base[i]) ? got_q[i][base[i]] : -1);
            end
            for (int k = 0; k < exp_q[i].size() && base[i] + k < got_q[i].size(); k++) begin
                checks++;
                if (got_q[i][base[i] + k] != exp_q[i][k]) begin
                    failures++;
                    $display("FAIL trig_fifo%0d_data[%0d] got=%0d required=%0d", 1 << i, k, got_q[i][base[i] + k], exp_q[i][k]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_done_handshake();
        test_toggle();
        test_short4();
        test_random();
        test_reset_mid();
`ifdef ADC_CAPTURE_TRIGGER_EN
        test_trigger();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
